// File: rtl/pcie_arbitro_fsm.sv
// Central controller of the 4-class switch: sequences RESET/INIT/IDLE/ACTIVE/ERROR and round-robins input pops.
// Latency: pop_in is combinational in ACTIVE; the matching push_out is registered and follows one cycle later.
// Backpressure: a class whose destination output FIFO is almost full is skipped; other classes keep flowing.
module pcie_arbitro_fsm #(
  parameter int UMBRALES_L_H = 8,
  parameter int NUM_FIFOS    = 4
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      init,
  input  logic [UMBRALES_L_H-1:0]   umbral_L_in,
  input  logic [UMBRALES_L_H-1:0]   umbral_H_in,
  input  logic [NUM_FIFOS-1:0]      fifo_empty_in,
  input  logic [2*NUM_FIFOS-1:0]    head_dest,
  input  logic [NUM_FIFOS-1:0]      almost_full_out,
  input  logic [NUM_FIFOS-1:0]      fifo_error,
  output logic [NUM_FIFOS-1:0]      pop_in,
  output logic [NUM_FIFOS-1:0]      push_out,
  output logic [UMBRALES_L_H-1:0]   umbral_L,
  output logic [UMBRALES_L_H-1:0]   umbral_H,
  output logic [2:0]                state,
  output logic                      idle_out,
  output logic                      error_out
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'b000,
    ST_INIT   = 3'b001,
    ST_IDLE   = 3'b010,
    ST_ACTIVE = 3'b011,
    ST_ERROR  = 3'b100
  } state_t;

  state_t                 state_q;
  state_t                 state_nxt;
  logic [1:0]             rr_ptr;
  logic [NUM_FIFOS-1:0]   elig;
  logic                   grant_vld;
  logic [1:0]             grant_idx;
  logic [1:0]             cand;
  logic [1:0]             grant_dest;
  logic                   grant_fire;

  assign state = state_q;

  always_comb begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      elig[i] = !fifo_empty_in[i] && !almost_full_out[head_dest[2*i +: 2]];
    end
  end

  // Search from rr_ptr with natural 2-bit wrap so 3 rolls over to 0.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    cand      = rr_ptr;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      cand = rr_ptr + 2'(k);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_fire = (state_q == ST_ACTIVE) && grant_vld;
  assign grant_dest = head_dest[2*grant_idx +: 2];
  assign pop_in     = grant_fire ? (NUM_FIFOS'(1) << grant_idx) : '0;

  always_comb begin
    state_nxt = state_q;
    if (state_q == ST_ERROR || (state_q != ST_RESET && |fifo_error)) begin
      state_nxt = ST_ERROR;
    end else begin
      case (state_q)
        ST_RESET:  state_nxt = ST_INIT;
        ST_INIT:   state_nxt = init ? ST_INIT : ST_IDLE;
        ST_IDLE: begin
          if (init)                state_nxt = ST_INIT;
          else if (!(&fifo_empty_in)) state_nxt = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (init)                state_nxt = ST_INIT;
          else if (&fifo_empty_in) state_nxt = ST_IDLE;
        end
        default:   state_nxt = ST_ERROR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= ST_RESET;
      umbral_L  <= '0;
      umbral_H  <= '0;
      push_out  <= '0;
      rr_ptr    <= '0;
      idle_out  <= 1'b0;
      error_out <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      idle_out  <= (state_nxt == ST_IDLE);
      error_out <= (state_nxt == ST_ERROR);
      if (state_q == ST_INIT) begin
        umbral_L <= umbral_L_in;
        umbral_H <= umbral_H_in;
      end
      // A grant made on the edge that leaves ACTIVE still pushes; only ERROR kills it.
      if (state_nxt == ST_ERROR) begin
        push_out <= '0;
      end else begin
        push_out <= grant_fire ? (NUM_FIFOS'(1) << grant_dest) : '0;
        if (grant_fire) rr_ptr <= grant_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pcie_arbitro_fsm.sv
// Randomized and directed bench for pcie_arbitro_fsm against a cycle-level reference model.
module tb_pcie_arbitro_fsm;

  logic       clk;
  logic       reset_L;
  logic       init;
  logic [7:0] umbral_L_in;
  logic [7:0] umbral_H_in;
  logic [3:0] fifo_empty_in;
  logic [7:0] head_dest;
  logic [3:0] almost_full_out;
  logic [3:0] fifo_error;
  logic [3:0] pop_in;
  logic [3:0] push_out;
  logic [7:0] umbral_L;
  logic [7:0] umbral_H;
  logic [2:0] state;
  logic       idle_out;
  logic       error_out;

  int checks = 0;
  int errors = 0;

  // Reference model: state codes 0 RESET,1 INIT,2 IDLE,3 ACTIVE,4 ERROR
  int         m_state;
  int         m_rr;
  logic [3:0] m_push;
  logic [7:0] m_L;
  logic [7:0] m_H;

  pcie_arbitro_fsm #(.UMBRALES_L_H(8), .NUM_FIFOS(4)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umbral_L_in(umbral_L_in), .umbral_H_in(umbral_H_in),
    .fifo_empty_in(fifo_empty_in), .head_dest(head_dest),
    .almost_full_out(almost_full_out), .fifo_error(fifo_error),
    .pop_in(pop_in), .push_out(push_out),
    .umbral_L(umbral_L), .umbral_H(umbral_H),
    .state(state), .idle_out(idle_out), .error_out(error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  function automatic int m_grant();
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (m_rr + k) % 4;
      if (!fifo_empty_in[i] && !almost_full_out[head_dest[2*i +: 2]]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_pop();
    int g;
    if (m_state != 3) return 4'b0;
    g = m_grant();
    if (g < 0) return 4'b0;
    return 4'b1 << g;
  endfunction

  task automatic model_reset();
    m_state = 0; m_rr = 0; m_push = 4'b0; m_L = 8'h0; m_H = 8'h0;
  endtask

  task automatic tick();
    int g, ns, nrr;
    logic [3:0] np;
    logic [7:0] nl, nh;
    g = (m_state == 3) ? m_grant() : -1;
    ns = m_state; nrr = m_rr; np = 4'b0; nl = m_L; nh = m_H;
    if (m_state == 1) begin nl = umbral_L_in; nh = umbral_H_in; end
    if (m_state == 4 || (m_state != 0 && fifo_error != 4'b0)) begin
      ns = 4;
    end else begin
      if (g >= 0) begin
        np  = 4'b1 << head_dest[2*g +: 2];
        nrr = (g + 1) % 4;
      end
      case (m_state)
        0: ns = 1;
        1: ns = init ? 1 : 2;
        2: ns = init ? 1 : ((fifo_empty_in != 4'hf) ? 3 : 2);
        3: ns = init ? 1 : ((fifo_empty_in == 4'hf) ? 2 : 3);
        default: ns = 4;
      endcase
    end
    @(posedge clk);
    #1;
    m_state = ns; m_rr = nrr; m_push = np; m_L = nl; m_H = nh;
  endtask

  task automatic drive(input logic i, input logic [3:0] e, input logic [7:0] hd,
                       input logic [3:0] af, input logic [3:0] fe);
    init = i; fifo_empty_in = e; head_dest = hd; almost_full_out = af; fifo_error = fe;
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0; init = 1'b1; umbral_L_in = 8'd2; umbral_H_in = 8'd6;
    fifo_empty_in = 4'hf; head_dest = 8'h0; almost_full_out = 4'h0; fifo_error = 4'h0;
    model_reset();
    #3;
    checks++;
    if ({state, pop_in, push_out, idle_out, error_out} !== 13'b0 || umbral_L !== 8'd0 || umbral_H !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got st=%0d pop=%b push=%b idle=%b err=%b L=%0d H=%0d want all 0",
               state, pop_in, push_out, idle_out, error_out, umbral_L, umbral_H);
    end
    @(negedge clk);
    reset_L = 1'b1;
    tick();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL reset_to_init got %0d want 1", state); end
    tick();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL init_hold got %0d want 1", state); end
    init = 1'b0;
    tick();
    checks++;
    if (state !== 3'd2 || idle_out !== 1'b1 || umbral_L !== 8'd2 || umbral_H !== 8'd6) begin
      errors++;
      $display("FAIL init_to_idle got st=%0d idle=%b L=%0d H=%0d want st=2 idle=1 L=2 H=6",
               state, idle_out, umbral_L, umbral_H);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    drive(1'b0, 4'b0000, 8'b11100100, 4'b0000, 4'b0000);
    tick();
    checks++;
    if (state !== 3'd3 || idle_out !== 1'b0) begin
      errors++; $display("FAIL rr_enter_active got st=%0d idle=%b want 3 0", state, idle_out);
    end
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (pop_in !== exp_seq[n] || pop_in !== m_pop()) begin
        errors++; $display("FAIL rr_pop[%0d] got %b want %b", n, pop_in, exp_seq[n]);
      end
      tick();
      checks++;
      if (push_out !== exp_seq[n] || push_out !== m_push) begin
        errors++; $display("FAIL rr_push[%0d] got %b want %b", n, push_out, exp_seq[n]);
      end
    end
  endtask

  task automatic test_blocking();
    drive(1'b0, 4'b1100, 8'b00001111, 4'b1000, 4'b0000);
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (pop_in !== 4'b0000) begin errors++; $display("FAIL blk_pop[%0d] got %b want 0000", n, pop_in); end
      tick();
      checks++;
      if (push_out !== m_push) begin errors++; $display("FAIL blk_push[%0d] got %b want %b", n, push_out, m_push); end
    end
    drive(1'b0, 4'b1100, 8'b00001111, 4'b0000, 4'b0000);
    checks++;
    if (pop_in !== 4'b0010 || pop_in !== m_pop()) begin
      errors++; $display("FAIL blk_resume got %b want 0010", pop_in);
    end
    tick();
    checks++;
    if (push_out !== 4'b1000 || pop_in !== 4'b0001) begin
      errors++; $display("FAIL blk_next got push=%b pop=%b want 1000 0001", push_out, pop_in);
    end
    tick();
  endtask

  task automatic test_per_dest();
    drive(1'b0, 4'b1010, 8'b00100000, 4'b0001, 4'b0000);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (pop_in !== 4'b0100 || pop_in !== m_pop()) begin
        errors++; $display("FAIL pd_pop[%0d] got %b want 0100", n, pop_in);
      end
      tick();
      checks++;
      if (push_out !== 4'b0100) begin errors++; $display("FAIL pd_push[%0d] got %b want 0100", n, push_out); end
    end
  endtask

  task automatic test_reinit();
    logic [3:0] pend;
    umbral_L_in = 8'd1; umbral_H_in = 8'd5;
    drive(1'b1, 4'b0000, 8'b11100100, 4'b0000, 4'b0000);
    checks++;
    if (pop_in !== m_pop() || pop_in === 4'b0000) begin
      errors++; $display("FAIL ri_last_pop got %b want %b", pop_in, m_pop());
    end
    pend = m_pop();
    tick();
    checks++;
    if (state !== 3'd1 || pop_in !== 4'b0000 || push_out !== pend || push_out !== m_push) begin
      errors++; $display("FAIL ri_init got st=%0d pop=%b push=%b want 1 0000 %b", state, pop_in, push_out, pend);
    end
    init = 1'b0;
    tick();
    checks++;
    if (state !== 3'd2 || push_out !== 4'b0000 || umbral_L !== 8'd1 || umbral_H !== 8'd5) begin
      errors++; $display("FAIL ri_idle got st=%0d push=%b L=%0d H=%0d want 2 0000 1 5",
                         state, push_out, umbral_L, umbral_H);
    end
    tick();
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL ri_active got %0d want 3", state); end
  endtask

  task automatic test_random();
    logic [18:0] got, want;
    for (int n = 0; n < 300; n++) begin
      umbral_L_in = 8'($urandom); umbral_H_in = 8'($urandom);
      drive(($urandom_range(0, 15) == 0), 4'($urandom), 8'($urandom), 4'($urandom & $urandom), 4'b0000);
      checks++;
      if (pop_in !== m_pop()) begin errors++; $display("FAIL rnd_pop[%0d] got %b want %b", n, pop_in, m_pop()); end
      tick();
      got  = {push_out, state, idle_out, error_out, umbral_L[3:0], umbral_H[3:0]};
      want = {m_push, 3'(m_state), (m_state == 2), (m_state == 4), m_L[3:0], m_H[3:0]};
      checks++;
      if (got !== want || umbral_L !== m_L || umbral_H !== m_H) begin
        errors++; $display("FAIL rnd_regs[%0d] got %h want %h", n, got, want);
      end
    end
  endtask

  task automatic test_error();
    int guard;
    drive(1'b0, 4'b0000, 8'b11100100, 4'b0000, 4'b0000);
    guard = 0;
    while (m_state != 3 && guard < 8) begin tick(); guard++; end
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL err_reach_active got %0d want 3", state); end
    drive(1'b0, 4'b0000, 8'b11100100, 4'b0000, 4'b0010);
    tick();
    checks++;
    if (state !== 3'd4 || error_out !== 1'b1 || pop_in !== 4'b0 || push_out !== 4'b0) begin
      errors++; $display("FAIL err_enter got st=%0d err=%b pop=%b push=%b want 4 1 0000 0000",
                         state, error_out, pop_in, push_out);
    end
    drive(1'b1, 4'b0000, 8'b11100100, 4'b0000, 4'b0000);
    for (int n = 0; n < 3; n++) tick();
    checks++;
    if (state !== 3'd4 || error_out !== 1'b1 || idle_out !== 1'b0) begin
      errors++; $display("FAIL err_sticky got st=%0d err=%b want 4 1", state, error_out);
    end
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({state, pop_in, push_out, idle_out, error_out} !== 13'b0 || umbral_L !== 8'd0 || umbral_H !== 8'd0) begin
      errors++; $display("FAIL err_async_reset got st=%0d pop=%b push=%b err=%b L=%0d",
                         state, pop_in, push_out, error_out, umbral_L);
    end
    @(negedge clk);
    reset_L = 1'b1;
    tick();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL err_restart got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_blocking();
    test_per_dest();
    test_reinit();
    test_random();
    test_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
